uart_rs232_rx: RTL
==================

UART_RS232_RX -- requirements
Module: uart_rs232_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, meaning clocks per bit period (115200 baud at 50 MHz).
REQ-002 The block SHALL have port Clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-003 The block SHALL have port Rst, input, 1 bit, an asynchronous, active-high reset.
REQ-004 The block SHALL have port Rx, input, 1 bit, the asynchronous serial line, idle high.
REQ-005 The block SHALL have port NBits, input, 4 bits, the data bits per frame; legal values are 1..8, and 0 or any value above 8 is treated as 8.
REQ-006 The block SHALL have port RxData, output, 8 bits, the last correctly framed word.
REQ-007 The block SHALL have port RxDone, output, 1 bit, a one-cycle pulse meaning a new word is valid on RxData.
REQ-008 The block SHALL have port RxErr, output, 1 bit, a one-cycle pulse meaning a framing error (stop bit sampled low).
REQ-009 The block SHALL have port Busy, output, 1 bit, high whenever the state is not IDLE.

Function
REQ-010 Rx SHALL pass through a 2-flop synchronizer; all sampling uses the synchronized value rx_s.
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP and WAIT_IDLE.
REQ-012 In IDLE, rx_s = 0 SHALL move the FSM to START, clear the bit counter and clear the clock counter.
REQ-013 In START, at clock count (CLKS_PER_BIT-1)/2 (216 at default):
  - rx_s = 0: go to DATA and clear the clock counter.
  - rx_s = 1: treat as a glitch and return to IDLE with no pulse.
REQ-014 NBits SHALL be latched on the IDLE->START transition; a change to NBits mid-frame has no effect on the current frame.
REQ-015 In DATA, each bit SHALL be sampled when the clock counter reaches CLKS_PER_BIT-1, i.e. at mid-bit; the counter then clears.
REQ-016 Data bits SHALL be received LSB first.
REQ-017 After N = latched NBits samples, the word SHALL be right-aligned in bits [N-1:0], upper bits zero, and the FSM goes to STOP.
REQ-018 In STOP, the stop bit SHALL be sampled at mid-bit (count CLKS_PER_BIT-1):
  - rx_s = 1: load RxData, pulse RxDone for exactly one cycle, go to IDLE.
  - rx_s = 0: leave RxData unchanged, pulse RxErr for one cycle, go to WAIT_IDLE.
REQ-019 WAIT_IDLE SHALL stay until rx_s = 1, then go to IDLE, so that a break or stuck-low line yields exactly one RxErr and no false starts.
REQ-020 RxDone and RxErr SHALL never be asserted in the same cycle.
REQ-021 RxData SHALL change only in the cycle RxDone asserts and SHALL hold its value otherwise.
REQ-022 Latency SHALL be fixed: RxDone rises (CLKS_PER_BIT-1)/2 + (N+1)*CLKS_PER_BIT + 3 ±1 clocks after the Rx falling edge, the 3 covering synchronizer delay.
REQ-023 A new start bit SHALL be accepted in the first IDLE cycle after RxDone, which allows back-to-back frames with one stop bit.
REQ-024 The clock counter SHALL be wide enough for CLKS_PER_BIT-1 (at least 9 bits at default) and SHALL never wrap within a bit.

Reset
REQ-025 Rst high SHALL asynchronously force:
  - state IDLE;
  - RxData = 8'h00, RxDone = 0, RxErr = 0, Busy = 0;
  - counters 0, synchronizer flops 1.
REQ-026 Rst asserted mid-frame SHALL abort the frame with no RxDone or RxErr pulse; after release, reception resumes at the next falling edge.

Verification
REQ-027 Scenario: NBits = 8, send 8'hA5 with 1 stop bit at CLKS_PER_BIT = 434 -> one RxDone pulse, RxData = 8'hA5, RxErr stays 0.
REQ-028 Scenario: NBits = 5, send 5'b10110 -> RxData = 8'h16, one RxDone pulse; then NBits = 0, send 8'hFF -> RxData = 8'hFF.
REQ-029 Scenario: send 8'h3C with the stop bit driven low, then hold Rx low for 3 bit times -> exactly one RxErr pulse, RxData unchanged, no RxDone, Busy high until Rx returns high.
REQ-030 Scenario: 100-clock low glitch on an idle Rx -> no RxDone, no RxErr, back in IDLE by clock 220.
REQ-031 Scenario: back-to-back frames 8'h55 then 8'hAA with no idle gap -> two RxDone pulses with 8'h55 then 8'hAA.
REQ-032 Scenario: assert Rst during data bit 4 of a frame, release, send 8'h81 -> RxData = 8'h00 right after reset, then 8'h81, and exactly one RxDone in total.

Source files
------------

// File: rtl/uart_rs232_rx.sv
// RS-232 style UART receiver: 2-flop synchronised Rx, mid-bit sampling, 1..8 data bits LSB first,
// one stop bit, with a one-cycle done/error pulse per frame.
module uart_rs232_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Rx,
  input  logic [3:0] NBits,
  output logic [7:0] RxData,
  output logic       RxDone,
  output logic       RxErr,
  output logic       Busy
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } state_e;

  state_e          r_state, w_state_d;
  logic            r_rx_meta, r_rx_s;
  logic [CntW-1:0] r_clk_cnt, w_clk_cnt_d;
  logic [3:0]      r_bit_cnt, w_bit_cnt_d;
  logic [3:0]      r_nbits, w_nbits_d;
  logic [7:0]      r_shift, w_shift_d;
  logic [7:0]      r_data, w_data_d;
  logic            r_done, w_done_d;
  logic            r_err, w_err_d;
  logic [3:0]      w_nbits_eff;

  // Out-of-range widths collapse to a full byte.
  assign w_nbits_eff = ((NBits == 4'd0) || (NBits > 4'd8)) ? 4'd8 : NBits;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= Rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= StIdle;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_nbits   <= 4'd8;
      r_shift   <= '0;
      r_data    <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_clk_cnt <= w_clk_cnt_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_nbits   <= w_nbits_d;
      r_shift   <= w_shift_d;
      r_data    <= w_data_d;
      r_done    <= w_done_d;
      r_err     <= w_err_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_clk_cnt_d = r_clk_cnt;
    w_bit_cnt_d = r_bit_cnt;
    w_nbits_d   = r_nbits;
    w_shift_d   = r_shift;
    w_data_d    = r_data;
    w_done_d    = 1'b0;
    w_err_d     = 1'b0;
    case (r_state)
      StIdle: begin
        if (!r_rx_s) begin
          w_state_d   = StStart;
          w_clk_cnt_d = '0;
          w_bit_cnt_d = '0;
          w_nbits_d   = w_nbits_eff;
          w_shift_d   = '0;
        end
      end
      StStart: begin
        if (r_clk_cnt == CntHalf) begin
          w_clk_cnt_d = '0;
          // A line that is high again at mid start bit was only a glitch.
          w_state_d   = r_rx_s ? StIdle : StData;
        end else begin
          w_clk_cnt_d = r_clk_cnt + 1'b1;
        end
      end
      StData: begin
        if (r_clk_cnt == CntMax) begin
          w_clk_cnt_d = '0;
          w_shift_d[r_bit_cnt[2:0]] = r_rx_s;
          w_bit_cnt_d = r_bit_cnt + 4'd1;
          if (r_bit_cnt == (r_nbits - 4'd1)) begin
            w_state_d = StStop;
          end
        end else begin
          w_clk_cnt_d = r_clk_cnt + 1'b1;
        end
      end
      StStop: begin
        if (r_clk_cnt == CntMax) begin
          w_clk_cnt_d = '0;
          if (r_rx_s) begin
            w_data_d  = r_shift;
            w_done_d  = 1'b1;
            w_state_d = StIdle;
          end else begin
            w_err_d   = 1'b1;
            w_state_d = StWaitIdle;
          end
        end else begin
          w_clk_cnt_d = r_clk_cnt + 1'b1;
        end
      end
      StWaitIdle: begin
        if (r_rx_s) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign RxData = r_data;
  assign RxDone = r_done;
  assign RxErr  = r_err;
  assign Busy   = (r_state != StIdle);

endmodule
